// File: rtl/mandelbrot_iter_scheduler.sv
// Recirculating iteration scheduler for a pipelined Mandelbrot datapath: tagged slot table,
// registered issue port and FWFT result FIFO. Define MANDEL_SCHED_STATS_EN for pixel/iteration counters.
module mandelbrot_iter_scheduler #(
  parameter int W      = 32,
  parameter int FRAC   = 28,
  parameter int TAG_W  = 3,
  parameter int ITER_W = 10,
  parameter int ID_W   = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ITER_W-1:0] max_iter,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [W-1:0]      pix_cx,
  input  logic [W-1:0]      pix_cy,
  input  logic [ID_W-1:0]   pix_id,
  output logic              iss_valid,
  output logic [TAG_W-1:0]  iss_tag,
  output logic [W-1:0]      iss_x,
  output logic [W-1:0]      iss_y,
  output logic [W-1:0]      iss_cx,
  output logic [W-1:0]      iss_cy,
  input  logic              ret_valid,
  input  logic [TAG_W-1:0]  ret_tag,
  input  logic [W-1:0]      ret_x,
  input  logic [W-1:0]      ret_y,
  input  logic [W-1:0]      ret_mag,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ID_W-1:0]   res_id,
  output logic [ITER_W-1:0] res_iter,
  output logic              res_escaped,
  output logic              busy
`ifdef MANDEL_SCHED_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [31:0]       stat_pixels,
  output logic [31:0]       stat_iters
`endif
);
  localparam int NSLOTS = 1 << TAG_W;
  localparam logic [W-1:0] THRESH = W'(64'd1 << (FRAC + 2));

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ITER_W-1:0] iter;
    logic              esc;
  } res_t;

  logic [NSLOTS-1:0]             alloc_q;
  logic [NSLOTS-1:0][W-1:0]      cx_q, cy_q;
  logic [NSLOTS-1:0][ID_W-1:0]   id_q;
  logic [NSLOTS-1:0][ITER_W-1:0] iter_q;
  logic [TAG_W:0]                alloc_cnt_q, alloc_cnt_d;

  res_t [NSLOTS-1:0]             mem_q;
  res_t                          head_q, head_d, push_ent;
  logic [TAG_W-1:0]              rd_ptr_q, rd_ptr_d, wr_ptr_q;
  logic [TAG_W:0]                fifo_cnt_q, fifo_cnt_d;
  logic                          res_valid_q, busy_q;

  logic                          iss_valid_q;
  logic [TAG_W-1:0]              iss_tag_q;
  logic [W-1:0]                  iss_x_q, iss_y_q, iss_cx_q, iss_cy_q;

  logic [ITER_W-1:0]             iter_r, mi_eff;
  logic [TAG_W-1:0]              free_tag;
  logic                          hit, esc, lim, done, recirc, any_free, accept, pop;

  always_comb begin
    iter_r   = iter_q[ret_tag];
    mi_eff   = (max_iter == '0) ? ITER_W'(1) : max_iter;
    hit      = ret_valid & alloc_q[ret_tag];
    esc      = ret_mag >= THRESH;
    lim      = ({1'b0, iter_r} + (ITER_W+1)'(1)) >= {1'b0, mi_eff};
    done     = hit & (esc | lim);
    recirc   = hit & ~done;
    free_tag = '0;
    any_free = 1'b0;
    for (int i = NSLOTS - 1; i >= 0; i--) begin
      if (!alloc_q[i]) begin
        free_tag = TAG_W'(i);
        any_free = 1'b1;
      end
    end
    // Credit: allocated + queued never exceeds NSLOTS, so a push always has room.
    pix_ready = ~(ret_valid & ~done) & any_free &
                (({1'b0, alloc_cnt_q} + {1'b0, fifo_cnt_q}) < (TAG_W+2)'(NSLOTS));
    accept    = pix_valid & pix_ready;
    pop       = res_valid_q & res_ready;

    push_ent.id   = id_q[ret_tag];
    push_ent.iter = esc ? iter_r : mi_eff;
    push_ent.esc  = esc;

    alloc_cnt_d = alloc_cnt_q + (TAG_W+1)'(accept) - (TAG_W+1)'(done);
    fifo_cnt_d  = fifo_cnt_q + (TAG_W+1)'(done) - (TAG_W+1)'(pop);
    rd_ptr_d    = rd_ptr_q + TAG_W'(pop);
    // Bypass the push into the head register when it lands at the new read pointer.
    head_d      = (done && wr_ptr_q == rd_ptr_d) ? push_ent : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_q     <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      id_q        <= '0;
      iter_q      <= '0;
      alloc_cnt_q <= '0;
    end else begin
      alloc_cnt_q <= alloc_cnt_d;
      if (done)   alloc_q[ret_tag] <= 1'b0;
      if (recirc) iter_q[ret_tag]  <= iter_r + ITER_W'(1);
      if (accept) begin
        alloc_q[free_tag] <= 1'b1;
        cx_q[free_tag]    <= pix_cx;
        cy_q[free_tag]    <= pix_cy;
        id_q[free_tag]    <= pix_id;
        iter_q[free_tag]  <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q <= 1'b0;
      iss_tag_q   <= '0;
      iss_x_q     <= '0;
      iss_y_q     <= '0;
      iss_cx_q    <= '0;
      iss_cy_q    <= '0;
    end else begin
      iss_valid_q <= recirc | accept;
      if (recirc) begin
        iss_tag_q <= ret_tag;
        iss_x_q   <= ret_x;
        iss_y_q   <= ret_y;
        iss_cx_q  <= cx_q[ret_tag];
        iss_cy_q  <= cy_q[ret_tag];
      end else if (accept) begin
        iss_tag_q <= free_tag;
        iss_x_q   <= '0;
        iss_y_q   <= '0;
        iss_cx_q  <= pix_cx;
        iss_cy_q  <= pix_cy;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q       <= '0;
      head_q      <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (done) begin
        mem_q[wr_ptr_q] <= push_ent;
        wr_ptr_q        <= wr_ptr_q + TAG_W'(1);
      end
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      head_q      <= head_d;
      res_valid_q <= fifo_cnt_d != '0;
      busy_q      <= (alloc_cnt_d != '0) || (fifo_cnt_d != '0);
    end
  end

`ifdef MANDEL_SCHED_STATS_EN
  logic [31:0] stat_pixels_q, stat_iters_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pixels_q <= '0;
      stat_iters_q  <= '0;
    end else if (stat_clr) begin
      stat_pixels_q <= '0;
      stat_iters_q  <= '0;
    end else begin
      if (pop && stat_pixels_q != '1)   stat_pixels_q <= stat_pixels_q + 32'd1;
      if (recirc && stat_iters_q != '1) stat_iters_q  <= stat_iters_q + 32'd1;
    end
  end

  assign stat_pixels = stat_pixels_q;
  assign stat_iters  = stat_iters_q;
`endif

  assign iss_valid   = iss_valid_q;
  assign iss_tag     = iss_tag_q;
  assign iss_x       = iss_x_q;
  assign iss_y       = iss_y_q;
  assign iss_cx      = iss_cx_q;
  assign iss_cy      = iss_cy_q;
  assign res_valid   = res_valid_q;
  assign res_id      = head_q.id;
  assign res_iter    = head_q.iter;
  assign res_escaped = head_q.esc;
  assign busy        = busy_q;
endmodule

// File: tb/tb_mandelbrot_iter_scheduler.sv
// Directed bench for mandelbrot_iter_scheduler with a latency-4 behavioural z^2+c datapath.
module tb_mandelbrot_iter_scheduler;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  max_iter;
  logic        pix_valid, pix_ready;
  logic [31:0] pix_cx, pix_cy;
  logic [19:0] pix_id;
  logic        iss_valid;
  logic [2:0]  iss_tag;
  logic [31:0] iss_x, iss_y, iss_cx, iss_cy;
  logic        ret_valid;
  logic [2:0]  ret_tag;
  logic [31:0] ret_x, ret_y, ret_mag;
  logic        res_valid, res_ready;
  logic [19:0] res_id;
  logic [9:0]  res_iter;
  logic        res_escaped, busy;
`ifdef MANDEL_SCHED_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_pixels, stat_iters;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mandelbrot_iter_scheduler dut (
    .clk(clk), .rst_n(rst_n), .max_iter(max_iter),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_cx(pix_cx), .pix_cy(pix_cy), .pix_id(pix_id),
    .iss_valid(iss_valid), .iss_tag(iss_tag), .iss_x(iss_x), .iss_y(iss_y), .iss_cx(iss_cx), .iss_cy(iss_cy),
    .ret_valid(ret_valid), .ret_tag(ret_tag), .ret_x(ret_x), .ret_y(ret_y), .ret_mag(ret_mag),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_iter(res_iter),
    .res_escaped(res_escaped), .busy(busy)
`ifdef MANDEL_SCHED_STATS_EN
    , .stat_clr(stat_clr), .stat_pixels(stat_pixels), .stat_iters(stat_iters)
`endif
  );

  // Return path: behavioural datapath (dp_en=1) or directly driven by the tasks (dp_en=0).
  logic        dp_en;
  logic        m_valid, t_valid;
  logic [2:0]  m_tag, t_tag;
  logic [31:0] m_x, m_y, m_mag, t_x, t_y, t_mag;
  assign ret_valid = dp_en ? m_valid : t_valid;
  assign ret_tag   = dp_en ? m_tag   : t_tag;
  assign ret_x     = dp_en ? m_x     : t_x;
  assign ret_y     = dp_en ? m_y     : t_y;
  assign ret_mag   = dp_en ? m_mag   : t_mag;

  bit        pv[4];
  bit [2:0]  pt[4];
  bit [31:0] px[4], py[4], pm[4];
  always @(negedge clk) begin
    longint sx, sy, x2, y2, xy;
    m_valid = pv[3]; m_tag = pt[3]; m_x = px[3]; m_y = py[3]; m_mag = pm[3];
    for (int i = 3; i > 0; i--) begin
      pv[i] = pv[i-1]; pt[i] = pt[i-1]; px[i] = px[i-1]; py[i] = py[i-1]; pm[i] = pm[i-1];
    end
    sx = longint'($signed(iss_x));
    sy = longint'($signed(iss_y));
    x2 = (sx * sx) >>> 28;
    y2 = (sy * sy) >>> 28;
    xy = (sx * sy) >>> 27;
    pv[0] = iss_valid;
    pt[0] = iss_tag;
    px[0] = 32'(x2 - y2 + longint'($signed(iss_cx)));
    py[0] = 32'(xy + longint'($signed(iss_cy)));
    pm[0] = 32'(x2 + y2);
  end

  // Issue counter per tag and log of popped results.
  int          iss_cnt[8];
  logic [19:0] r_id[$];
  logic [9:0]  r_iter[$];
  logic        r_esc[$];
  always @(negedge clk) begin
    #2;
    if (iss_valid) iss_cnt[iss_tag]++;
    if (res_valid && res_ready) begin
      r_id.push_back(res_id);
      r_iter.push_back(res_iter);
      r_esc.push_back(res_escaped);
    end
  end

  task automatic send_pix(input logic [31:0] cx, input logic [31:0] cy, input logic [19:0] id,
                          output bit ok);
    ok = 1'b0;
    @(negedge clk);
    pix_valid = 1'b1; pix_cx = cx; pix_cy = cy; pix_id = id;
    for (int i = 0; i < 300 && !ok; i++) begin
      #1;
      if (pix_ready) ok = 1'b1;
      @(negedge clk);
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_res(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (r_id.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp += 6;
    if (iss_valid !== 1'b0) begin n_err++; $display("FAIL reset_iss_valid got %b want 0", iss_valid); end
    if ({iss_tag, iss_x, iss_y, iss_cx, iss_cy} !== '0) begin
      n_err++; $display("FAIL reset_iss_data got %h want 0", {iss_tag, iss_x, iss_y, iss_cx, iss_cy});
    end
    if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    if ({res_id, res_iter, res_escaped} !== '0) begin
      n_err++; $display("FAIL reset_res_data got %h want 0", {res_id, res_iter, res_escaped});
    end
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    if (pix_ready !== 1'b1) begin n_err++; $display("FAIL idle_pix_ready got %b want 1", pix_ready); end
  endtask

  task automatic test_no_escape;
    bit ok;
    int b0 = iss_cnt[0];
    int rb = r_id.size();
    send_pix(32'h0, 32'h0, 20'h00011, ok);
    wait_res(rb + 1, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL noesc_timeout got %0d results want %0d", r_id.size(), rb + 1); end
    else begin
      n_cmp += 4;
      if (r_id[rb] !== 20'h00011) begin n_err++; $display("FAIL noesc_id got %h want 00011", r_id[rb]); end
      if (r_iter[rb] !== 10'd16) begin n_err++; $display("FAIL noesc_iter got %0d want 16", r_iter[rb]); end
      if (r_esc[rb] !== 1'b0) begin n_err++; $display("FAIL noesc_escaped got %b want 0", r_esc[rb]); end
      if (iss_cnt[0] - b0 != 16) begin n_err++; $display("FAIL noesc_issues got %0d want 16", iss_cnt[0] - b0); end
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL noesc_busy_idle got %b want 0", busy); end
  endtask

  task automatic test_escape;
    bit ok;
    int b0 = iss_cnt[0];
    int rb = r_id.size();
    send_pix(32'h2000_0000, 32'h0, 20'h00022, ok);
    wait_res(rb + 1, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL esc_timeout got %0d results want %0d", r_id.size(), rb + 1); end
    else begin
      n_cmp += 4;
      if (r_id[rb] !== 20'h00022) begin n_err++; $display("FAIL esc_id got %h want 00022", r_id[rb]); end
      if (r_iter[rb] !== 10'd1) begin n_err++; $display("FAIL esc_iter got %0d want 1", r_iter[rb]); end
      if (r_esc[rb] !== 1'b1) begin n_err++; $display("FAIL esc_escaped got %b want 1", r_esc[rb]); end
      if (iss_cnt[0] - b0 != 2) begin n_err++; $display("FAIL esc_issues got %0d want 2", iss_cnt[0] - b0); end
    end
    repeat (4) @(negedge clk);
  endtask

`ifdef MANDEL_SCHED_STATS_EN
  task automatic test_stats;
    n_cmp += 4;
    if (stat_pixels !== 32'd2) begin n_err++; $display("FAIL stat_pixels got %0d want 2", stat_pixels); end
    if (stat_iters !== 32'd16) begin n_err++; $display("FAIL stat_iters got %0d want 16", stat_iters); end
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    if (stat_pixels !== 32'd0) begin n_err++; $display("FAIL stat_pixels_clr got %0d want 0", stat_pixels); end
    if (stat_iters !== 32'd0) begin n_err++; $display("FAIL stat_iters_clr got %0d want 0", stat_iters); end
  endtask
`endif

  task automatic test_back_to_back;
    logic [31:0] bx[8] = '{32'h0, 32'h2000_0000, 32'h1000_0000, 32'h0,
                           32'hE000_0000, 32'h0, 32'h1000_0000, 32'h0};
    logic [31:0] by[8] = '{32'h0, 32'h0, 32'h0, 32'h1000_0000,
                           32'h0, 32'h2000_0000, 32'h0, 32'h0};
    logic [9:0]  ei[8] = '{10'd16, 10'd1, 10'd2, 10'd16, 10'd1, 10'd1, 10'd2, 10'd16};
    logic        ee[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    bit ok;
    int nacc = 0;
    int rdy_seen = 0;
    int rb = r_id.size();
    res_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      send_pix(bx[k], by[k], 20'h00100 + 20'(k), ok);
      if (ok) nacc++;
    end
    n_cmp++;
    if (nacc != 8) begin n_err++; $display("FAIL b2b_accepted got %0d want 8", nacc); end
    @(negedge clk);
    pix_valid = 1'b1; pix_cx = 32'h0; pix_cy = 32'h0; pix_id = 20'h001FF;
    repeat (400) begin
      #1;
      if (pix_ready) rdy_seen++;
      @(negedge clk);
    end
    pix_valid = 1'b0;
    n_cmp += 4;
    if (rdy_seen != 0) begin n_err++; $display("FAIL b2b_ready_while_full got %0d cycles want 0", rdy_seen); end
    if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy got %b want 1", busy); end
    if (res_valid !== 1'b1) begin n_err++; $display("FAIL b2b_res_valid got %b want 1", res_valid); end
    if (r_id.size() != rb) begin n_err++; $display("FAIL b2b_no_pop got %0d want %0d", r_id.size(), rb); end
    res_ready = 1'b1;
    wait_res(rb + 8, ok);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (r_id.size() != rb + 8) begin n_err++; $display("FAIL b2b_drain_count got %0d want %0d", r_id.size() - rb, 8); end
    else begin
      for (int k = 0; k < 8; k++) begin
        int hits = 0;
        int at = 0;
        for (int j = rb; j < rb + 8; j++)
          if (r_id[j] == 20'h00100 + 20'(k)) begin hits++; at = j; end
        n_cmp++;
        if (hits != 1) begin n_err++; $display("FAIL b2b_id_%0d got %0d copies want 1", k, hits); end
        else begin
          n_cmp++;
          if (r_iter[at] !== ei[k] || r_esc[at] !== ee[k])
            begin n_err++; $display("FAIL b2b_res_%0d got iter %0d esc %b want iter %0d esc %b", k, r_iter[at], r_esc[at], ei[k], ee[k]); end
        end
      end
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_after got %b want 0", busy); end
  endtask

  task automatic test_collision;
    bit ok;
    dp_en = 1'b0;
    t_valid = 1'b0;
    send_pix(32'h0, 32'h0, 20'h00055, ok);
    n_cmp += 2;
    if (!ok) begin n_err++; $display("FAIL coll_first_accept got 0 want 1"); end
    if (iss_valid !== 1'b1 || iss_tag !== 3'd0) begin
      n_err++; $display("FAIL coll_first_issue got v%b tag %0d want v1 tag 0", iss_valid, iss_tag);
    end
    t_valid = 1'b1; t_tag = 3'd0; t_mag = 32'h0; t_x = 32'h0123_4560; t_y = 32'h0FED_CBA0;
    pix_valid = 1'b1; pix_cx = 32'h0AAA_0000; pix_cy = 32'h0555_0000; pix_id = 20'h00077;
    #1;
    n_cmp++;
    if (pix_ready !== 1'b0) begin n_err++; $display("FAIL coll_ready_blocked got %b want 0", pix_ready); end
    @(negedge clk);
    t_valid = 1'b0;
    n_cmp += 2;
    if (iss_valid !== 1'b1 || iss_tag !== 3'd0) begin
      n_err++; $display("FAIL coll_recirc_tag got v%b tag %0d want v1 tag 0", iss_valid, iss_tag);
    end
    if (iss_x !== 32'h0123_4560 || iss_y !== 32'h0FED_CBA0 || iss_cx !== 32'h0) begin
      n_err++; $display("FAIL coll_recirc_data got %h %h %h want 01234560 0fedcba0 0", iss_x, iss_y, iss_cx);
    end
    #1;
    n_cmp++;
    if (pix_ready !== 1'b1) begin n_err++; $display("FAIL coll_ready_later got %b want 1", pix_ready); end
    @(negedge clk);
    pix_valid = 1'b0;
    n_cmp += 2;
    if (iss_valid !== 1'b1 || iss_tag !== 3'd1) begin
      n_err++; $display("FAIL coll_new_tag got v%b tag %0d want v1 tag 1", iss_valid, iss_tag);
    end
    if (iss_x !== 32'h0 || iss_cx !== 32'h0AAA_0000 || iss_cy !== 32'h0555_0000) begin
      n_err++; $display("FAIL coll_new_data got %h %h %h want 0 0aaa0000 05550000", iss_x, iss_cx, iss_cy);
    end
  endtask

  task automatic test_reset_midflight;
    bit ok;
    int nacc = 0;
    int bad = 0;
    int rb = r_id.size();
    for (int k = 0; k < 3; k++) begin
      send_pix(32'h0300_0000, 32'h0100_0000, 20'h00080 + 20'(k), ok);
      if (ok) nacc++;
    end
    n_cmp += 3;
    if (nacc != 3) begin n_err++; $display("FAIL rst_fill got %0d want 3", nacc); end
    if (busy !== 1'b1 || iss_tag !== 3'd4) begin
      n_err++; $display("FAIL rst_pre_state got busy %b tag %0d want busy 1 tag 4", busy, iss_tag);
    end
    rst_n = 1'b0;
    #1;
    if ({iss_valid, busy, res_valid, iss_tag, iss_x, iss_cx, iss_cy, res_id} !== '0) begin
      n_err++; $display("FAIL rst_outputs got v%b b%b r%b tag %0d cx %h", iss_valid, busy, res_valid, iss_tag, iss_cx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      t_valid = 1'b1; t_tag = 3'(k); t_x = 32'h0100_0000; t_y = 32'h0;
      t_mag = k[0] ? 32'h4000_0000 : 32'h0;
      if (res_valid || iss_valid) bad++;
    end
    @(negedge clk);
    t_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (res_valid || iss_valid) bad++;
    end
    n_cmp += 3;
    if (bad != 0) begin n_err++; $display("FAIL rst_stale_activity got %0d cycles want 0", bad); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy_after got %b want 0", busy); end
    if (r_id.size() != rb) begin n_err++; $display("FAIL rst_stale_results got %0d want 0", r_id.size() - rb); end
  endtask

  initial begin
    rst_n = 1'b0; max_iter = 10'd16; pix_valid = 1'b0; pix_cx = '0; pix_cy = '0; pix_id = '0;
    res_ready = 1'b1; dp_en = 1'b1;
    t_valid = 1'b0; t_tag = '0; t_x = '0; t_y = '0; t_mag = '0;
`ifdef MANDEL_SCHED_STATS_EN
    stat_clr = 1'b0;
`endif
    test_reset;
    test_no_escape;
    test_escape;
`ifdef MANDEL_SCHED_STATS_EN
    test_stats;
`endif
    test_back_to_back;
    test_collision;
    test_reset_midflight;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
